// File: rtl/cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_pkg : state encodings, opcode constants and helpers shared by  |
// |           the cpu_sequencer block.          Rev 1.0                |
// +--------------------------------------------------------------------+
package cpu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_e;

   localparam logic [3:0]  OP_JMP       = 4'hE;
   localparam logic [3:0]  OP_HLT       = 4'hF;
   // Opcodes below this value are ALU operations.
   localparam logic [3:0]  OP_ALU_LIMIT = 4'h8;
   localparam logic [15:0] RETIRED_MAX  = 16'hFFFF;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == RETIRED_MAX) ? v : v + 16'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_pc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_pc : program counter with reset, wrapping increment and load.  |
// |                                             Rev 1.0                |
// +--------------------------------------------------------------------+
module seq_pc
   import cpu_pkg::*;
#(
   parameter int PC_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inc,
   input  logic            load,
   input  logic [PC_W-1:0] load_val,
   output logic [PC_W-1:0] pc
);

   localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;

   // Load wins over increment; the addition wraps naturally at 2^PC_W.
   always_comb begin
      pc_d = pc_q;
      if (load) begin
         pc_d = load_val;
      end else if (inc) begin
         pc_d = pc_q + PC_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_sequencer : fetch/decode/exec/writeback control FSM with       |
// |                 registered outputs.         Rev 1.0                |
// +--------------------------------------------------------------------+
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int PC_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [7:0]      imem_rdata,
   output logic [3:0]      op,
   output logic [3:0]      imm,
   output logic            alu_go,
   input  logic            alu_done,
   output logic            reg_we,
   output logic [PC_W-1:0] pc,
   output logic [15:0]     retired,
   output logic            halted,
   output logic [2:0]      state
);

   state_e      state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic [3:0]  imm_q, imm_d;
   logic [15:0] retired_q, retired_d;
   logic        imem_req_q, imem_req_d;
   logic        alu_go_q, alu_go_d;
   logic        reg_we_q, reg_we_d;
   logic        halted_q, halted_d;
   logic        pc_inc;
   logic        pc_load;

   seq_pc #(.PC_W(PC_W)) u_seq_pc (
      .clk      (clk),
      .rst      (rst),
      .inc      (pc_inc),
      .load     (pc_load),
      .load_val (PC_W'(imm_q)),
      .pc       (pc)
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      imm_d     = imm_q;
      retired_d = retired_q;
      pc_inc    = 1'b0;
      pc_load   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (imem_ack) begin
               op_d    = imem_rdata[7:4];
               imm_d   = imem_rdata[3:0];
               pc_inc  = 1'b1;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (op_q < OP_ALU_LIMIT) begin
               state_d = ST_EXEC;
            end else if (op_q == OP_JMP) begin
               pc_load   = 1'b1;
               retired_d = sat_inc(retired_q);
               state_d   = ST_FETCH;
            end else if (op_q == OP_HLT) begin
               retired_d = sat_inc(retired_q);
               state_d   = ST_HALT;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_EXEC: begin
            if (alu_done) state_d = ST_WB;
         end
         ST_WB: begin
            retired_d = sat_inc(retired_q);
            state_d   = run ? ST_FETCH : ST_IDLE;
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are registered versions of what the next state implies.
      imem_req_d = (state_d == ST_FETCH);
      alu_go_d   = (state_q == ST_DECODE) && (state_d == ST_EXEC);
      reg_we_d   = (state_d == ST_WB);
      halted_d   = (state_d == ST_HALT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         op_q       <= 4'h0;
         imm_q      <= 4'h0;
         retired_q  <= 16'h0000;
         imem_req_q <= 1'b0;
         alu_go_q   <= 1'b0;
         reg_we_q   <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         imm_q      <= imm_d;
         retired_q  <= retired_d;
         imem_req_q <= imem_req_d;
         alu_go_q   <= alu_go_d;
         reg_we_q   <= reg_we_d;
         halted_q   <= halted_d;
      end
   end

   assign imem_req  = imem_req_q;
   assign imem_addr = pc;
   assign op        = op_q;
   assign imm       = imm_q;
   assign alu_go    = alu_go_q;
   assign reg_we    = reg_we_q;
   assign retired   = retired_q;
   assign halted    = halted_q;
   assign state     = state_q;

endmodule
`default_nettype wire
